// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: FSM state encoding, the cache
// line size and the default parameter values used by every file of the block.
package dma_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_SIZE_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_BUF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dma_ctrl_if.sv
// Bundle of the DMA command, read-channel and write-channel signals.
// The master modport is the DMA engine; the slave modport is the host and
// memory side that starts transfers and answers requests.
interface dma_ctrl_if
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  // Command
  logic                  go;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SIZE_WIDTH-1:0] size;
  logic                  done;

  // Read channel
  logic                  rd_req_en;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_req_full;
  logic                  rd_rsp_valid;
  logic [DATA_WIDTH-1:0] rd_rsp_data;

  // Write channel
  logic                  wr_req_en;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_req_full;
  logic                  wr_rsp_valid;

  modport master (
    input  go, rd_addr, wr_addr, size,
    input  rd_req_full, rd_rsp_valid, rd_rsp_data,
    input  wr_req_full, wr_rsp_valid,
    output done,
    output rd_req_en, rd_req_addr,
    output wr_req_en, wr_req_addr, wr_req_data
  );

  modport slave (
    output go, rd_addr, wr_addr, size,
    output rd_req_full, rd_rsp_valid, rd_rsp_data,
    output wr_req_full, wr_rsp_valid,
    input  done,
    input  rd_req_en, rd_req_addr,
    input  wr_req_en, wr_req_addr, wr_req_data
  );

endinterface

// File: rtl/dma_ctrl_fifo.sv
// First-word-fall-through line buffer between the read responses and the
// write requests. The head entry is always visible on o_data; o_count gives
// the occupancy used by the read credit logic.
module fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Qualify push/pop so that misuse can never corrupt the pointers.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    w_do_pop  = i_pop && (r_count != '0);
    w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);
  end

  // Pointer and occupancy tracking; a push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking <= so every update sees pre-edge values.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Line storage.
  // NOTE: the array is deliberately not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/dma_ctrl.sv
// Cache-line copy engine. Reads `size` lines starting at rd_addr, buffers the
// in-order responses, and writes them to wr_addr onwards. Read issue is
// throttled by a credit rule so that lines in flight plus lines buffered
// never exceed the buffer depth. Completion is counted on write responses.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input logic        clk,
  input logic        rst,
  dma_ctrl_if.master bus
);

  // Counters carry one extra bit so the largest size never wraps them.
  localparam int CW    = SIZE_WIDTH + 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int IW    = ((CW > CNT_W) ? CW : CNT_W) + 1;

  state_t                r_state;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [CW-1:0]         r_size;
  logic [CW-1:0]         r_reads_issued;
  logic [CW-1:0]         r_reads_received;
  logic [CW-1:0]         r_writes_issued;
  logic [CW-1:0]         r_writes_completed;

  logic                  r_rd_req_en;
  logic [ADDR_WIDTH-1:0] r_rd_req_addr;
  logic                  r_wr_req_en;
  logic [ADDR_WIDTH-1:0] r_wr_req_addr;
  logic [DATA_WIDTH-1:0] r_wr_req_data;

  logic                  w_busy;
  logic                  w_push;
  logic                  w_rd_issue;
  logic                  w_wr_issue;
  logic [IW-1:0]         w_in_flight;
  logic [CW-1:0]         w_completed_nxt;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic [CNT_W-1:0]      w_fifo_count;

  // Buffer for read data awaiting its write slot.
  fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.rd_rsp_data),
    .i_pop   (w_wr_issue),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Issue decisions: credit-limited reads, buffer-driven writes; responses
  // outside BUSY are dropped.
  always_comb begin
    w_busy          = (r_state == ST_BUSY);
    w_push          = w_busy && bus.rd_rsp_valid;
    w_in_flight     = IW'(r_reads_issued - r_reads_received) + IW'(w_fifo_count);
    w_rd_issue      = w_busy && (r_reads_issued < r_size) && !bus.rd_req_full &&
                      (w_in_flight < IW'(BUF_DEPTH));
    w_wr_issue      = w_busy && !w_fifo_empty && !bus.wr_req_full;
    w_completed_nxt = r_writes_completed + CW'(w_busy && bus.wr_rsp_valid);
  end

  // Control FSM with counters and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_done             <= 1'b0;
      r_rd_addr          <= '0;
      r_wr_addr          <= '0;
      r_size             <= '0;
      r_reads_issued     <= '0;
      r_reads_received   <= '0;
      r_writes_issued    <= '0;
      r_writes_completed <= '0;
      r_rd_req_en        <= 1'b0;
      r_rd_req_addr      <= '0;
      r_wr_req_en        <= 1'b0;
      r_wr_req_addr      <= '0;
      r_wr_req_data      <= '0;
    end else begin
      r_rd_req_en <= 1'b0;
      r_wr_req_en <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A zero-length transfer reaches DONE with done still low, so it
          // rises one cycle later here.
          if (r_state == ST_DONE) r_done <= 1'b1;
          if (bus.go) begin
            r_rd_addr          <= bus.rd_addr;
            r_wr_addr          <= bus.wr_addr;
            r_size             <= {1'b0, bus.size};
            r_reads_issued     <= '0;
            r_reads_received   <= '0;
            r_writes_issued    <= '0;
            r_writes_completed <= '0;
            r_done             <= 1'b0;
            r_state            <= (bus.size == '0) ? ST_DONE : ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (w_rd_issue) begin
            r_rd_req_en    <= 1'b1;
            r_rd_req_addr  <= r_rd_addr;
            r_rd_addr      <= r_rd_addr + ADDR_WIDTH'(LINE_BYTES);
            r_reads_issued <= r_reads_issued + CW'(1);
          end
          if (w_push) r_reads_received <= r_reads_received + CW'(1);
          if (w_wr_issue) begin
            r_wr_req_en     <= 1'b1;
            r_wr_req_addr   <= r_wr_addr;
            r_wr_req_data   <= w_fifo_head;
            r_wr_addr       <= r_wr_addr + ADDR_WIDTH'(LINE_BYTES);
            r_writes_issued <= r_writes_issued + CW'(1);
          end
          r_writes_completed <= w_completed_nxt;
          // Look at the post-increment count so done follows the last
          // write response by exactly one cycle.
          if (w_completed_nxt == r_size) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.done        = r_done;
  assign bus.rd_req_en   = r_rd_req_en;
  assign bus.rd_req_addr = r_rd_req_addr;
  assign bus.wr_req_en   = r_wr_req_en;
  assign bus.wr_req_addr = r_wr_req_addr;
  assign bus.wr_req_data = r_wr_req_data;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: a cycle-stepped memory model answers reads and
// writes with fixed latencies, and per-transfer tallies are compared against
// hand-computed expectations.
module tb_dma_ctrl;
  import dma_pkg::*;

  localparam int AW = 64;
  localparam int SW = 16;
  localparam int DW = 512;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_ctrl_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  dma_ctrl #(
    .ADDR_WIDTH (AW),
    .SIZE_WIDTH (SW),
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory model configuration and per-transfer tallies
  int          cyc = 0;
  int          rd_lat = 1;
  int          wr_lat = 1;
  bit          rand_bp = 1'b0;
  int          wr_full_until = 0;
  int          go_cyc;
  logic [63:0] exp_rd_base, exp_wr_base;
  int          rd_seen, wr_seen, addr_errs, data_errs, max_gap;
  int          done_rises, done_rise_cyc, last_wr_rsp_cyc;
  bit          prev_done = 1'b0;
  int          rd_due[$];
  logic [63:0] rd_q_addr[$];
  int          wr_due[$];

  function automatic logic [DW-1:0] line_of(input logic [63:0] a);
    return {4{a, ~a}};
  endfunction

  // One clock: observe DUT outputs just after the edge, then drive responses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.rd_rsp_valid = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    if (bus.rd_req_en) begin
      if (bus.rd_req_addr !== exp_rd_base + 64'(rd_seen) * 64'd64) addr_errs++;
      rd_seen++;
      rd_due.push_back(cyc + rd_lat);
      rd_q_addr.push_back(bus.rd_req_addr);
    end
    if (bus.wr_req_en) begin
      if (bus.wr_req_addr !== exp_wr_base + 64'(wr_seen) * 64'd64) addr_errs++;
      if (bus.wr_req_data !== line_of(exp_rd_base + 64'(wr_seen) * 64'd64)) data_errs++;
      wr_seen++;
      wr_due.push_back(cyc + wr_lat);
    end
    if (rd_seen - wr_seen > max_gap) max_gap = rd_seen - wr_seen;
    if (bus.done && !prev_done) begin
      done_rises++;
      done_rise_cyc = cyc;
    end
    prev_done = bus.done;
    if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_data  = line_of(rd_q_addr[0]);
      void'(rd_due.pop_front());
      void'(rd_q_addr.pop_front());
    end
    if (wr_due.size() > 0 && wr_due[0] <= cyc) begin
      bus.wr_rsp_valid = 1'b1;
      last_wr_rsp_cyc  = cyc;
      void'(wr_due.pop_front());
    end
    bus.rd_req_full = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.wr_req_full = rand_bp ? 1'($urandom_range(0, 1)) : (cyc < wr_full_until);
  endtask

  task automatic clear_tally(input logic [63:0] ra, input logic [63:0] wa);
    exp_rd_base     = ra;
    exp_wr_base     = wa;
    rd_seen         = 0;
    wr_seen         = 0;
    addr_errs       = 0;
    data_errs       = 0;
    max_gap         = 0;
    done_rises      = 0;
    done_rise_cyc   = -1;
    last_wr_rsp_cyc = -1;
  endtask

  task automatic start(input logic [63:0] ra, input logic [63:0] wa, input int sz);
    clear_tally(ra, wa);
    bus.rd_addr = ra;
    bus.wr_addr = wa;
    bus.size    = SW'(sz);
    bus.go      = 1'b1;
    go_cyc      = cyc;
    step();
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_in_budget"}, 64'(bus.done), 64'd1);
  endtask

  task automatic settle_and_tally(input string tag, input int sz);
    repeat (6) step();
    check({tag, "_reads"},      64'(rd_seen),    64'(sz));
    check({tag, "_writes"},     64'(wr_seen),    64'(sz));
    check({tag, "_addr_errs"},  64'(addr_errs),  64'd0);
    check({tag, "_data_errs"},  64'(data_errs),  64'd0);
    check({tag, "_done_rises"}, 64'(done_rises), 64'd1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.go           = 1'b0;
    bus.rd_addr      = '0;
    bus.wr_addr      = '0;
    bus.size         = '0;
    bus.rd_req_full  = 1'b0;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data  = '0;
    bus.wr_req_full  = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    clear_tally(64'd0, 64'd0);
    repeat (3) step();
    check("rst_done",      64'(bus.done),      64'd0);
    check("rst_rd_req_en", 64'(bus.rd_req_en), 64'd0);
    check("rst_wr_req_en", 64'(bus.wr_req_en), 64'd0);
    rst = 1'b0;
    step();

    // Single line, no backpressure
    rd_lat = 1;
    wr_lat = 1;
    start(64'h1000, 64'h2000, 1);
    wait_done("t1", 100);
    check("t1_done_after_wr_rsp", 64'(done_rise_cyc), 64'(last_wr_rsp_cyc + 1));
    settle_and_tally("t1", 1);
    check("t1_done_holds", 64'(bus.done), 64'd1);

    // Zero-length transfer from DONE
    start(64'h3000, 64'h4000, 0);
    check("t2_go_clears_done", 64'(bus.done), 64'd0);
    wait_done("t2", 20);
    check("t2_done_two_after_go", 64'(done_rise_cyc), 64'(go_cyc + 2));
    repeat (6) step();
    check("t2_reads",  64'(rd_seen), 64'd0);
    check("t2_writes", 64'(wr_seen), 64'd0);

    // Credit limit: slow reads, writes blocked for 100 cycles
    rd_lat          = 20;
    wr_lat          = 2;
    wr_full_until   = cyc + 101;
    bus.wr_req_full = 1'b1;
    start(64'h1_0000, 64'h8_0000, 40);
    wait_done("t3", 2000);
    settle_and_tally("t3", 40);
    check("t3_max_in_flight", 64'(max_gap), 64'(BD));

    // Random backpressure on both channels
    rd_lat  = 3;
    wr_lat  = 2;
    rand_bp = 1'b1;
    start(64'h10_0000, 64'h20_0000, 100);
    wait_done("t4", 5000);
    rand_bp         = 1'b0;
    bus.rd_req_full = 1'b0;
    bus.wr_req_full = 1'b0;
    settle_and_tally("t4", 100);

    // Reset in the middle of a transfer, then a fresh one
    rd_lat = 2;
    wr_lat = 2;
    start(64'h5000, 64'h6000, 10);
    begin
      int n = 0;
      while (wr_seen < 5 && n < 500) begin
        step();
        n++;
      end
    end
    check("t5_reached_5_writes", 64'(wr_seen), 64'd5);
    rst = 1'b1;
    step();
    check("t5_rst_rd_req_en",   64'(bus.rd_req_en), 64'd0);
    check("t5_rst_wr_req_en",   64'(bus.wr_req_en), 64'd0);
    check("t5_rst_done",        64'(bus.done),      64'd0);
    check("t5_rst_rd_req_addr", bus.rd_req_addr,    64'd0);
    check("t5_rst_wr_req_addr", bus.wr_req_addr,    64'd0);
    rst = 1'b0;
    clear_tally(64'h5000, 64'h6000);
    repeat (30) step();
    check("t5_quiet_reads",  64'(rd_seen), 64'd0);
    check("t5_quiet_writes", 64'(wr_seen), 64'd0);
    start(64'h7000, 64'h9000, 3);
    wait_done("t5b", 200);
    settle_and_tally("t5b", 3);

    // go during BUSY must be ignored
    rd_lat = 4;
    wr_lat = 3;
    start(64'hA000, 64'hB000, 6);
    repeat (3) step();
    bus.rd_addr = 64'hF000;
    bus.wr_addr = 64'hE000;
    bus.size    = SW'(50);
    bus.go      = 1'b1;
    step();
    bus.go = 1'b0;
    wait_done("t6", 500);
    check("t6_done_after_wr_rsp", 64'(done_rise_cyc), 64'(last_wr_rsp_cyc + 1));
    settle_and_tally("t6", 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: width of the byte addresses.
REQ-002 Parameter SIZE_WIDTH, default 16: width of the transfer size, counted in cache lines.
REQ-003 Parameter DATA_WIDTH, default 512: width of one cache line in bits.
REQ-004 Parameter BUF_DEPTH, default 16: number of lines in the read-data buffer; SHALL be a power of 2, minimum 2.
REQ-005 clk  in  1  the single clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 go  in  1  single-cycle start pulse.
REQ-008 rd_addr / wr_addr  in  ADDR_WIDTH  starting read and write byte addresses; 64-byte aligned.
REQ-009 size  in  SIZE_WIDTH  number of cache lines to transfer.
REQ-010 done  out  1  transfer complete; level signal.
REQ-011 rd_req_en / rd_req_addr  out  1 / ADDR_WIDTH  read request and its address.
REQ-012 rd_req_full  in  1  read channel cannot accept a request.
REQ-013 rd_rsp_valid / rd_rsp_data  in  1 / DATA_WIDTH  in-order read response.
REQ-014 wr_req_en / wr_req_addr / wr_req_data  out  1 / ADDR_WIDTH / DATA_WIDTH  write request, its address and its data.
REQ-015 wr_req_full  in  1  write channel cannot accept a request.
REQ-016 wr_rsp_valid  in  1  one write has completed.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-018 IDLE or DONE with go=1: latch rd_addr, wr_addr and size; clear all counters; deassert done; enter BUSY on the next cycle.
REQ-019 go=1 with size=0: enter DONE directly; no requests are issued.
REQ-020 go SHALL be ignored while in BUSY.
REQ-021 Read issue condition: BUSY, reads_issued<size, rd_req_full=0, and (reads_issued-reads_received)+buffer_count < BUF_DEPTH (credit rule).
REQ-022 rd_req_en SHALL be asserted for exactly one cycle per issued read.
REQ-023 The k-th read SHALL use rd_req_addr = latched rd_addr + 64*k; wrap-around modulo 2**ADDR_WIDTH.
REQ-024 Every rd_rsp_valid SHALL push rd_rsp_data into the buffer; buffer overflow is impossible by REQ-021.
REQ-025 Write issue condition: buffer non-empty and wr_req_full=0.
REQ-026 A write SHALL pop the buffer head; the k-th write uses wr_req_addr = latched wr_addr + 64*k and wr_req_data = popped line.
REQ-027 Requests and data outputs SHALL be registered: a write issues one cycle after the pop decision.
REQ-028 Request/response latency SHALL be one cycle minimum from rd_rsp_valid to wr_req_en.
REQ-029 A simultaneous buffer push and pop SHALL leave the buffer count unchanged.
REQ-030 A response and a new issue in the same cycle SHALL both be counted.
REQ-031 BUSY to DONE SHALL occur when writes_completed = size (count of wr_rsp_valid); done=1 from the following cycle.
REQ-032 done SHALL stay 1 in DONE until the next accepted go.
REQ-033 wr_rsp_valid or rd_rsp_valid arriving in IDLE or DONE SHALL be ignored.
REQ-034 All counters SHALL be SIZE_WIDTH+1 bits wide, so that size = 2**SIZE_WIDTH-1 is handled without overflow.

Reset
REQ-035 rst=1 SHALL force IDLE, done=0, rd_req_en=0, wr_req_en=0, all counters=0, buffer empty, address registers=0.
REQ-036 rst asserted mid-transfer SHALL abort the transfer, with no further requests from the next cycle; in-flight responses after reset are ignored.

Structure
REQ-037 Package dma_pkg SHALL hold the state enum, the LINE_BYTES=64 constant and the default parameter values.
REQ-038 The read-data buffer SHALL be a separate sub-module, fifo (DATA_WIDTH x BUF_DEPTH, synchronous reset, first-word-fall-through, with count output).

Verification
REQ-039 size=1, rd_addr=h1000, wr_addr=h2000, no backpressure -> one read at h1000, one write at h2000 carrying the response data, done=1 one cycle after wr_rsp_valid.
REQ-040 size=0 with go -> no rd_req_en and no wr_req_en; done=1 two cycles after go.
REQ-041 size=40, BUF_DEPTH=16, responses delayed 20 cycles, wr_req_full held 1 for 100 cycles -> outstanding+buffered never exceeds 16; 40 writes in order at wr_addr+64k with matching data.
REQ-042 rd_req_full and wr_req_full each toggled randomly 50% of cycles, size=100 -> exactly 100 reads and 100 writes, no duplicates or gaps, done asserted once.
REQ-043 rst pulsed after 5 of 10 writes -> outputs reach reset values the next cycle; a following go with size=3 completes correctly.
REQ-044 go pulsed again during BUSY -> ignored: latched addresses and size unchanged, done timing unchanged.
